// File: rtl/dma_r_burst_ctrl.sv
// Read-side DMA sequencer: splits one (address, word count) command into AXI INCR
// bursts that never cross a 4 KB page and streams the returned words downstream.
module dma_r_burst_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DMA_DATA_W = 32,
  parameter int LEN_W      = 8,
  parameter int CNT_W      = 16,
  parameter int MAX_BURST  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [CNT_W-1:0]      word_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  eng_valid,
  output logic [ADDR_W-1:0]     eng_addr,
  output logic [LEN_W-1:0]      eng_dma_len,
  input  logic                  eng_ready,
  input  logic [DMA_DATA_W-1:0] eng_rdata,
  input  logic                  eng_dma_ready,
  input  logic                  eng_error,
  output logic [DMA_DATA_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            dbg_state
);

  localparam int B      = DMA_DATA_W / 8;
  localparam int OFF_W  = $clog2(B);
  localparam int BEAT_W = LEN_W + 1;
  localparam int CW     = (CNT_W > 13) ? CNT_W : 13;

  typedef enum logic [1:0] {IDLE, WAIT_ENG, BURST, CHECK} state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   addr;
  logic [CNT_W-1:0]    remaining;
  logic [BEAT_W-1:0]   beats, beat_cnt, beats_next;
  logic [CW-1:0]       rem_w, bnd_w, cap_w, min_w;
  logic                accept, load_burst, finish, beat_hs, last_beat;

  // Burst size: smallest of words left, the burst cap and beats left in this 4 KB page.
  always_comb begin
    rem_w = CW'(remaining);
    bnd_w = CW'((13'd4096 - {1'b0, addr[11:0]}) >> OFF_W);
    cap_w = CW'(MAX_BURST);
    min_w = rem_w;
    if (cap_w < min_w) min_w = cap_w;
    if (bnd_w < min_w) min_w = bnd_w;
    beats_next = BEAT_W'(min_w);
  end

  // Handshake: a word moves only when the engine has data (eng_ready) and the
  // downstream can take it (out_ready); eng_valid is out_ready gated by BURST.
  assign eng_valid = (state == BURST) && out_ready;
  assign out_valid = (state == BURST) && eng_ready;
  assign out_data  = eng_rdata;
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign beat_hs   = eng_valid && eng_ready;
  assign last_beat = beat_hs && (beat_cnt == beats - BEAT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d    = state;
    accept     = 1'b0;
    load_burst = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (word_cnt != '0) state_d = WAIT_ENG;
          else                finish  = 1'b1;
        end
      end
      WAIT_ENG: begin
        if (eng_dma_ready) begin
          load_burst = 1'b1;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (last_beat) state_d = CHECK;
      end
      CHECK: begin
        if (remaining == '0) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT_ENG;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr        <= '0;
      remaining   <= '0;
      beats       <= '0;
      beat_cnt    <= '0;
      eng_addr    <= '0;
      eng_dma_len <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        addr      <= base_addr & ~ADDR_W'(B - 1);
        remaining <= word_cnt;
        error     <= 1'b0;
      end
      if (load_burst) begin
        eng_addr    <= addr;
        eng_dma_len <= LEN_W'(beats_next - BEAT_W'(1));
        beats       <= beats_next;
        beat_cnt    <= '0;
      end
      if (beat_hs) begin
        if (last_beat) begin
          addr      <= addr + (ADDR_W'(beats) << OFF_W);
          remaining <= remaining - CNT_W'(beats);
        end else begin
          beat_cnt <= beat_cnt + BEAT_W'(1);
        end
      end
      // The engine's rlast-mismatch flag is settled by the cycle after the last beat.
      if (state == CHECK && eng_error) error <= 1'b1;
    end
  end

endmodule

// File: doc/dma_r_burst_ctrl.md
Name: dma_r_burst_ctrl

Overview:
- Sequencer in front of the DMA AXI read engine.
- Accepts one transfer command (base address, word count) and splits it into AXI INCR bursts of at most MAX_BURST beats, none crossing a 4 KB boundary.
- Issues each burst to the engine's native slave I/F (valid/addr/dma_len) and forwards returned words to a valid/ready output stream.
- Reports busy, done and a sticky error to the DMA register file.

Parameters:
- ADDR_W, 32, byte address width (engine addr width).
- DMA_DATA_W, 32, data width; bytes per beat B = DMA_DATA_W/8, power of 2.
- LEN_W, 8, AXI len width (engine dma_len width).
- CNT_W, 16, transfer word-count width.
- MAX_BURST, 256, max beats per burst, 1..2^LEN_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle command strobe; sampled only in IDLE
- base_addr  in  ADDR_W  transfer start byte address; low log2(B) bits forced to 0
- word_cnt  in  CNT_W  words to read; 0 means empty transfer
- busy  out  1  high from accepted start until done
- done  out  1  1-cycle pulse at transfer end
- error  out  1  sticky; set if any burst ends with eng_error=1; cleared on accepted start
- eng_valid  out  1  to engine valid
- eng_addr  out  ADDR_W  to engine addr; current burst address
- eng_dma_len  out  LEN_W  to engine dma_len; beats-1 of current burst
- eng_ready  in  1  engine per-beat ready (read data valid)
- eng_rdata  in  DMA_DATA_W  engine read data
- eng_dma_ready  in  1  engine idle / ready for new burst
- eng_error  in  1  engine rlast mismatch flag
- out_data  out  DMA_DATA_W  = eng_rdata
- out_valid  out  1  word valid
- out_ready  in  1  downstream ready

Behaviour:
- Reset values: busy=0, done=0, error=0, eng_valid=0, eng_addr=0, eng_dma_len=0, out_valid=0; state=IDLE.
- States: IDLE, WAIT_ENG, BURST, CHECK.
- IDLE: start=1 -> latch addr/remaining, clear error, busy=1.
  - If word_cnt=0 -> done=1 next cycle, busy=0, stay IDLE.
  - Else -> WAIT_ENG.
- WAIT_ENG: when eng_dma_ready=1, register the burst and go to BURST. Burst size:
  - boundary beats = (4096 - addr[11:0]) >> log2(B)
  - beats = min(remaining, MAX_BURST, boundary beats)
  - eng_dma_len = beats-1 (LEN_W bits); eng_addr = addr.
- BURST:
  - eng_valid = out_ready; out_valid = eng_ready; out_data = eng_rdata (combinational, zero latency).
  - Beat handshake = eng_valid & eng_ready. On each beat, the beat counter increments.
  - On the handshake with beat counter = beats-1: eng_valid deasserts from the next cycle (never high in CHECK), addr += beats*B, remaining -= beats, go to CHECK.
- CHECK (1 cycle, engine error now registered): error |= eng_error.
  - remaining=0 -> done=1, busy=0, IDLE.
  - Else -> WAIT_ENG.
- Back-pressure: out_ready=0 holds eng_valid low; no beat is lost or duplicated.
- start while busy is ignored. Address arithmetic wraps modulo 2^ADDR_W.
- Reset mid-transfer: all state returns to reset values immediately; engine is reset on the same reset net.

Test Plan:
- base 0x1000, cnt 16, out_ready=1, B=4 -> one burst, eng_dma_len=15, eng_addr=0x1000, 16 words out in order, done pulse, error=0.
- base 0x0FF0, cnt 8 -> bursts (0x0FF0, len 3) then (0x1000, len 3); no 4 KB crossing; 8 words out; one done.
- base 0x0, cnt 600, MAX_BURST=256 -> bursts len 255, 255, 87 at 0x0, 0x400, 0x800; 600 words out; busy held throughout.
- cnt 0 -> no eng_valid, done pulse 1 cycle after start, busy drops the same cycle.
- Random out_ready toggling during cnt 32 -> 32 words out, each transferred exactly once, eng_valid tracks out_ready in BURST.
- Engine forces eng_error=1 at end of burst 1 of 2 -> error=1 persists through done; next start clears it to 0.
